// File: rtl/iopad_ctrl.sv
// Pad-side GPIO control: per-channel input synchroniser, glitch filter, sticky rise flag,
// and a registered output drive. Define IOPAD_LOOPBACK_EN to route core_in back to pad_out.

module iopad_in_lane #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_BITS   = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic pad,
    input  logic filt_act,
    input  logic evt_clr,
    output logic core,
    output logic evt
);
    // Accept on the FMAX-th consecutive mismatch, i.e. when cnt already holds FMAX-1.
    localparam logic [FILT_BITS-1:0] LIM = FILT_BITS'((1 << FILT_BITS) - 2);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [FILT_BITS-1:0]   cnt;
    logic                   core_d;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            cnt    <= '0;
            core   <= 1'b0;
            core_d <= 1'b0;
            evt    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
            if (!filt_act || s == core) begin
                core <= s;
                cnt  <= '0;
            end else if (cnt == LIM) begin
                core <= s;
                cnt  <= '0;
            end else begin
                cnt  <= cnt + 1'b1;
            end
            core_d <= core;
            // set beats clear when both land in the same cycle
            evt    <= (core & ~core_d) | (evt & ~evt_clr);
        end
    end
endmodule

module iopad_ctrl #(
    parameter int                   NUM_IN      = 16,
    parameter int                   NUM_OUT     = 16,
    parameter int                   SYNC_STAGES = 2,
    parameter int                   FILT_BITS   = 3,
    parameter logic [NUM_OUT-1:0]   OUT_RST     = {NUM_OUT{1'b0}}
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               test_mode,
    input  logic [NUM_IN-1:0]  pad_in,
    input  logic [NUM_IN-1:0]  filt_en,
    output logic [NUM_IN-1:0]  core_in,
    output logic [NUM_IN-1:0]  rise_evt,
    input  logic [NUM_IN-1:0]  evt_clr,
    input  logic [NUM_OUT-1:0] core_out,
    input  logic               loopback,
    output logic [NUM_OUT-1:0] pad_out
);
    logic [NUM_IN-1:0] filt_act;

    assign filt_act = filt_en & {NUM_IN{~test_mode}};

    iopad_in_lane #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_BITS   (FILT_BITS)
    ) u_lane [NUM_IN-1:0] (
        .clk      (clk),
        .reset    (reset),
        .pad      (pad_in),
        .filt_act (filt_act),
        .evt_clr  (evt_clr),
        .core     (core_in),
        .evt      (rise_evt)
    );

`ifdef IOPAD_LOOPBACK_EN
    // Output channels wrap around the input channels when NUM_OUT > NUM_IN.
    logic [NUM_OUT-1:0] lb_src;

    for (genvar j = 0; j < NUM_OUT; j++) begin : g_lb
        assign lb_src[j] = core_in[j % NUM_IN];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pad_out <= OUT_RST;
        else        pad_out <= loopback ? lb_src : core_out;
    end
`else
    logic unused_loopback;

    assign unused_loopback = loopback;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pad_out <= OUT_RST;
        else        pad_out <= core_out;
    end
`endif
endmodule

// File: tb/tb_iopad_ctrl.sv
// Self-checking bench for iopad_ctrl: directed scenarios followed by random traffic,
// all compared against a cycle-level behavioural model.

module tb_iopad_ctrl;
    localparam int              NI   = 16;
    localparam int              NO   = 16;
    localparam int              SS   = 2;
    localparam int              FB   = 3;
    localparam int              FMAX = (1 << FB) - 1;
    localparam logic [NO-1:0]   ORST = 16'hA5A5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          test_mode = 1'b0;
    logic [NI-1:0] pad_in = '0;
    logic [NI-1:0] filt_en = '0;
    logic [NI-1:0] core_in;
    logic [NI-1:0] rise_evt;
    logic [NI-1:0] evt_clr = '0;
    logic [NO-1:0] core_out = '0;
    logic          loopback = 1'b0;
    logic [NO-1:0] pad_out;

    always #5 clk = ~clk;

    iopad_ctrl #(
        .NUM_IN(NI), .NUM_OUT(NO), .SYNC_STAGES(SS), .FILT_BITS(FB), .OUT_RST(ORST)
    ) dut (
        .clk(clk), .reset(reset), .test_mode(test_mode), .pad_in(pad_in),
        .filt_en(filt_en), .core_in(core_in), .rise_evt(rise_evt), .evt_clr(evt_clr),
        .core_out(core_out), .loopback(loopback), .pad_out(pad_out)
    );

    int ntests = 0;
    int nfail  = 0;

    // model state: pad history (oldest first), accepted levels, mismatch run lengths
    logic [NI-1:0] hist[$];
    logic [NI-1:0] m_core, m_core_old, m_evt;
    logic [NO-1:0] m_pad;
    int            run[NI];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k < SS; k++) hist.push_back('0);
        m_core = '0; m_core_old = '0; m_evt = '0; m_pad = ORST;
        for (int i = 0; i < NI; i++) run[i] = 0;
    endtask

    task automatic model_edge();
        logic [NI-1:0] s, nc;
        logic [NO-1:0] lb;
        s = hist.pop_front();
        hist.push_back(pad_in);
        for (int i = 0; i < NI; i++) begin
            nc[i] = m_core[i];
            if (!(filt_en[i] && !test_mode)) begin
                nc[i] = s[i]; run[i] = 0;
            end else if (s[i] == m_core[i]) begin
                run[i] = 0;
            end else begin
                run[i]++;
                if (run[i] == FMAX) begin nc[i] = s[i]; run[i] = 0; end
            end
        end
        m_evt = (m_core & ~m_core_old) | (m_evt & ~evt_clr);
        for (int j = 0; j < NO; j++) lb[j] = m_core[j % NI];
`ifdef IOPAD_LOOPBACK_EN
        m_pad = loopback ? lb : core_out;
`else
        m_pad = core_out;
        if (lb == '1) m_pad = core_out;
`endif
        m_core_old = m_core;
        m_core = nc;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("core_in", 64'(core_in), 64'(m_core));
        chk("rise_evt", 64'(rise_evt), 64'(m_evt));
        chk("pad_out", 64'(pad_out), 64'(m_pad));
    endtask

    initial begin
        logic seen;
        core_out = ORST;
        #2 reset = 1'b0;
        #1;
        chk("rst_pad_out", 64'(pad_out), 64'(ORST));
        chk("rst_core_in", 64'(core_in), 64'h0);
        chk("rst_rise_evt", 64'(rise_evt), 64'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) step();
        chk("hold_pad_out", 64'(pad_out), 64'(ORST));

        // unfiltered path, 3-edge latency, sticky event
        pad_in[3] = 1'b1;
        step(); step();
        chk("unf_lat2", 64'(core_in[3]), 64'h0);
        step();
        chk("unf_lat3", 64'(core_in[3]), 64'h1);
        chk("unf_evt_early", 64'(rise_evt[3]), 64'h0);
        step();
        chk("unf_evt", 64'(rise_evt[3]), 64'h1);
        step(); step();
        chk("unf_evt_sticky", 64'(rise_evt[3]), 64'h1);
        evt_clr[3] = 1'b1;
        step();
        evt_clr[3] = 1'b0;
        chk("unf_evt_clr", 64'(rise_evt[3]), 64'h0);

        // glitch filter: 6-cycle pulse rejected
        filt_en[0] = 1'b1;
        pad_in[0] = 1'b1;
        seen = 1'b0;
        repeat (6) begin step(); seen |= core_in[0]; end
        pad_in[0] = 1'b0;
        repeat (6) begin step(); seen |= core_in[0]; end
        chk("filt_pulse6", 64'(seen), 64'h0);

        // 7-cycle level accepted on the 7th mismatch edge
        pad_in[0] = 1'b1;
        repeat (8) step();
        chk("filt_lat8", 64'(core_in[0]), 64'h0);
        step();
        chk("filt_lat9", 64'(core_in[0]), 64'h1);
        pad_in[0] = 1'b0;
        repeat (10) step();
        chk("filt_fall", 64'(core_in[0]), 64'h0);

        // test_mode bypasses the filter
        test_mode = 1'b1;
        pad_in[0] = 1'b1;
        seen = 1'b0;
        repeat (6) begin step(); seen |= core_in[0]; end
        pad_in[0] = 1'b0;
        repeat (4) begin step(); seen |= core_in[0]; end
        chk("tm_pass", 64'(seen), 64'h1);
        test_mode = 1'b0;

        // set/clear collision on channel 5
        evt_clr[5] = 1'b1;
        pad_in[5] = 1'b1;
        repeat (3) step();
        chk("coll_core", 64'(core_in[5]), 64'h1);
        step();
        chk("coll_set", 64'(rise_evt[5]), 64'h1);
        step();
        chk("coll_clr", 64'(rise_evt[5]), 64'h0);
        evt_clr[5] = 1'b0;

        // output register and asynchronous reset mid-stream
        core_out = 16'h1234;
        step();
        chk("out_lat", 64'(pad_out), 64'h1234);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_pad_out", 64'(pad_out), 64'(ORST));
        chk("mid_rst_core_in", 64'(core_in), 64'h0);
        chk("mid_rst_rise_evt", 64'(rise_evt), 64'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;

        // loopback
        filt_en = '0;
        pad_in = 16'hBEEF;
        repeat (4) step();
        chk("lb_core", 64'(core_in), 64'hBEEF);
        core_out = '0;
        loopback = 1'b1;
        step();
`ifdef IOPAD_LOOPBACK_EN
        chk("lb_pad", 64'(pad_out), 64'hBEEF);
`else
        chk("lb_pad", 64'(pad_out), 64'h0);
`endif
        loopback = 1'b0;

        // random traffic
        repeat (400) begin
            pad_in   = pad_in ^ NI'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 15) == 0) filt_en = NI'($urandom);
            if ($urandom_range(0, 19) == 0) test_mode = ~test_mode;
            evt_clr  = NI'($urandom & $urandom);
            core_out = NO'($urandom);
            loopback = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
